// File: rtl/booth_acc.sv
// Frame accumulator for the Booth multiplier product stream: sums signed terms
// until in_last, then holds the total for downstream. Define BOOTH_ACC_SAT_EN to clamp on overflow.
module booth_acc #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_p,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf
);

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef BOOTH_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             first;

    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] sum_next;
    logic             ovf_now;
    logic             accept;

    // The product is two's complement, so it must be sign-extended into the accumulator.
    assign term    = ACC_W'($signed(in_p));
    assign sum     = acc + term;
    assign ovf_now = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != term[ACC_W-1]);
    assign accept  = in_valid && in_ready;

`ifdef BOOTH_ACC_SAT_EN
    assign sum_next = ovf_now ? (term[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign sum_next = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // Registers are left as-is after the hand-off; 'first' makes the next term restart them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (accept) begin
            if (first) begin
                acc <= term;
                ovf <= 1'b0;
                cnt <= CNT_W'(1);
            end else begin
                acc <= sum_next;
                ovf <= ovf | ovf_now;
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            end
            first <= in_last;
        end
    end

    assign out_acc   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_booth_acc.sv
// Scoreboard bench for booth_acc: one 16-bit/8-bit-count instance and one
// 8-bit/2-bit-count instance share the same stimulus and are checked against a range-based model.
module tb_booth_acc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_p;
    logic       in_last;
    logic       out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [7:0]  out_acc_s;
    logic [1:0]  out_count_s;
    logic        out_ovf_s;

    int checks = 0;
    int errors = 0;

    booth_acc #(.WIDTH(4), .ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    booth_acc #(.WIDTH(4), .ACC_W(8), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_p(in_p), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_acc(out_acc_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] acc16;
        logic [7:0]  cnt16;
        logic        ovf16;
        logic [7:0]  acc8;
        logic [1:0]  cnt2;
        logic        ovf8;
    } exp_t;

    exp_t sb[$];

    bit m_first = 1'b1;
    int m_acc16, m_acc8, m_cnt16, m_cnt2;
    bit m_ovf16, m_ovf8;
    bit rnd_mode = 1'b0;

    // Exact integer sum, then range test; wrap or clamp on leaving the signed range.
    task automatic model_add(inout int acc, inout bit ovf, input int t, input int w);
        int e;
        int hi;
        int lo;
        e  = acc + t;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (e > hi || e < lo) begin
            ovf = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            acc = (t < 0) ? lo : hi;
`else
            acc = (e > hi) ? e - (1 << w) : e + (1 << w);
`endif
        end else begin
            acc = e;
        end
    endtask

    task automatic model_accept(input logic [7:0] p, input logic last);
        int   t;
        exp_t e;
        t = int'($signed(p));
        if (m_first) begin
            m_acc16 = t;  m_acc8 = t;
            m_cnt16 = 1;  m_cnt2 = 1;
            m_ovf16 = 0;  m_ovf8 = 0;
        end else begin
            model_add(m_acc16, m_ovf16, t, 16);
            model_add(m_acc8, m_ovf8, t, 8);
            m_cnt16 = (m_cnt16 == 255) ? 255 : m_cnt16 + 1;
            m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
        m_first = last;
        if (last) begin
            e.acc16 = m_acc16[15:0];
            e.cnt16 = m_cnt16[7:0];
            e.ovf16 = m_ovf16;
            e.acc8  = m_acc8[7:0];
            e.cnt2  = m_cnt2[1:0];
            e.ovf8  = m_ovf8;
            sb.push_back(e);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        sb.delete();
    endtask

    // Drive one term and hold it until the DUT takes it.
    task automatic send_term(input logic [7:0] p, input logic last);
        int waited;
        bit done;
        waited   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_p     = p;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(p, last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL send_term timeout: in_ready=%b required 1", in_ready);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: pending=%0d required 0", sb.size());
        end
    endtask

    // Scoreboard: compare on every output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: out_acc=%h with empty scoreboard", out_acc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if ({out_acc, out_count, out_ovf} !== {e.acc16, e.cnt16, e.ovf16}) begin
                    errors++;
                    $display("[TB] FAIL result16: acc=%h cnt=%0d ovf=%b required acc=%h cnt=%0d ovf=%b",
                             out_acc, out_count, out_ovf, e.acc16, e.cnt16, e.ovf16);
                end
                checks++;
                if ({out_valid_s, out_acc_s, out_count_s, out_ovf_s} !== {1'b1, e.acc8, e.cnt2, e.ovf8}) begin
                    errors++;
                    $display("[TB] FAIL result8: valid=%b acc=%h cnt=%0d ovf=%b required valid=1 acc=%h cnt=%0d ovf=%b",
                             out_valid_s, out_acc_s, out_count_s, out_ovf_s, e.acc8, e.cnt2, e.ovf8);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({in_ready, out_valid, out_acc, out_count, out_ovf, in_ready_s, out_valid_s, out_acc_s, out_count_s, out_ovf_s}
            !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 8'h0, 2'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL %s: rdy=%b vld=%b acc=%h cnt=%0d ovf=%b small rdy=%b vld=%b acc=%h cnt=%0d ovf=%b required rdy=1 all else 0",
                     name, in_ready, out_valid, out_acc, out_count, out_ovf,
                     in_ready_s, out_valid_s, out_acc_s, out_count_s, out_ovf_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_zero("reset_immediate");
        idle(2);
        check_zero("reset_held");
        rst = 1'b0;
        model_reset();
        idle(1);
        check_zero("after_reset");
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_term(8'h0F, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_midframe: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        send_term(8'hF2, 1'b1);
        checks++;
        if ({out_valid, in_ready, out_acc, out_count, out_ovf} !== {1'b1, 1'b0, 16'h0001, 8'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_latency: vld=%b rdy=%b acc=%h cnt=%0d ovf=%b required 1 0 0001 2 0",
                     out_valid, in_ready, out_acc, out_count, out_ovf);
        end
        wait_drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single_term();
        send_term(8'h80, 1'b1);
        checks++;
        if ({out_acc, out_count, out_acc_s} !== {16'hFF80, 8'd1, 8'h80}) begin
            errors++;
            $display("[TB] FAIL single_term: acc=%h cnt=%0d acc8=%h required FF80 1 80", out_acc, out_count, out_acc_s);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_term(8'h10, 1'b0);
        send_term(8'h05, 1'b1);
        in_valid = 1'b1;
        in_p     = 8'h03;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_acc, out_count, out_ovf} !== {1'b1, 1'b0, 16'h0015, 8'd2, 1'b0}) begin
                errors++;
                $display("[TB] FAIL hold_stable[%0d]: vld=%b rdy=%b acc=%h cnt=%0d ovf=%b required 1 0 0015 2 0",
                         i, out_valid, in_ready, out_acc, out_count, out_ovf);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        send_term(8'h03, 1'b1);
        checks++;
        if ({out_acc, out_count} !== {16'h0003, 8'd1}) begin
            errors++;
            $display("[TB] FAIL restart_after_hold: acc=%h cnt=%0d required 0003 1", out_acc, out_count);
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        logic [7:0] exp8;
`ifdef BOOTH_ACC_SAT_EN
        exp8 = 8'h7F;
`else
        exp8 = 8'h80;
`endif
        send_term(8'h7F, 1'b0);
        send_term(8'h01, 1'b1);
        checks++;
        if ({out_acc_s, out_ovf_s, out_acc, out_ovf} !== {exp8, 1'b1, 16'h0080, 1'b0}) begin
            errors++;
            $display("[TB] FAIL overflow: acc8=%h ovf8=%b acc16=%h ovf16=%b required %h 1 0080 0",
                     out_acc_s, out_ovf_s, out_acc, out_ovf, exp8);
        end
        wait_drain();
        send_term(8'h01, 1'b1);
        checks++;
        if ({out_acc_s, out_ovf_s} !== {8'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL overflow_cleared: acc8=%h ovf8=%b required 01 0", out_acc_s, out_ovf_s);
        end
        wait_drain();
        send_term(8'h80, 1'b0);
        send_term(8'hFF, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid_frame();
        send_term(8'h11, 1'b0);
        send_term(8'h22, 1'b0);
        send_term(8'h33, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_zero("reset_mid_frame");
        #2;
        rst = 1'b0;
        model_reset();
        idle(1);
        send_term(8'h02, 1'b0);
        send_term(8'h03, 1'b1);
        checks++;
        if ({out_acc, out_count} !== {16'd5, 8'd2}) begin
            errors++;
            $display("[TB] FAIL after_reset_frame: acc=%h cnt=%0d required 0005 2", out_acc, out_count);
        end
        wait_drain();
        out_ready = 1'b0;
        send_term(8'h44, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_zero("reset_in_hold");
        #2;
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        idle(1);
        send_term(8'hFE, 1'b1);
        wait_drain();
    endtask

    task automatic test_count_saturation();
        for (int i = 0; i < 5; i++) begin
            send_term(8'h01, (i == 4) ? 1'b1 : 1'b0);
        end
        checks++;
        if ({out_count_s, out_acc_s, out_count, out_acc} !== {2'd3, 8'd5, 8'd5, 16'd5}) begin
            errors++;
            $display("[TB] FAIL count_sat: cnt2=%0d acc8=%h cnt8=%0d acc16=%h required 3 05 5 0005",
                     out_count_s, out_acc_s, out_count, out_acc);
        end
        wait_drain();
    endtask

    task automatic test_idle_gaps();
        send_term(8'hF0, 1'b0);
        idle(4);
        send_term(8'h20, 1'b0);
        idle(2);
        send_term(8'hFD, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        send_term(8'h7F, 1'b0);
        send_term(8'h7F, 1'b1);
        send_term(8'h81, 1'b0);
        send_term(8'h81, 1'b1);
        send_term(8'h05, 1'b1);
        wait_drain();
    endtask

    task automatic test_random();
        int n;
        rnd_mode = 1'b1;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                idle($urandom_range(0, 2));
                send_term(8'($urandom), (k == n - 1) ? 1'b1 : 1'b0);
            end
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_p      = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_single_term();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_count_saturation();
        test_idle_gaps();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
